branch_predictor_bht: RTL and testbench

- Dynamic successor to the static backward-taken predictor in the RISC-V IF/ID front end.
- Holds a direct-mapped branch history table (BHT) of 2^IDX_BITS saturating counters, indexed by the branch PC.
- Predicts at IF, resolves at ID and supplies the next fetch PC every cycle.
- Trains the counters on resolution and raises `correct`=0 on a misprediction so the core flushes IF.

---
 rtl/branch_predictor_bht.sv | 129 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: direct-mapped table of saturating counters, IF lookup, ID resolve/train.
// Optional statistics counters are enabled with `define BRPRED_STATS_EN.
module branch_predictor_bht #(
  parameter int XLEN     = 32,
  parameter int IDX_BITS = 4,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            if_branch,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc_4,
  input  logic [XLEN-1:0] if_pc_imm,
  input  logic            id_branch,
  input  logic            id_taken,
  output logic [XLEN-1:0] pc_out,
  output logic            pred_taken,
  output logic            correct,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_RESET = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX   = '1;

  logic [IDX_BITS-1:0] idx;
  logic [DEPTH-1:0]    taken_vec;
  logic                train;

  logic                ctx_valid_reg;
  logic                ctx_pred_reg;
  logic [IDX_BITS-1:0] ctx_idx_reg;
  logic [XLEN-1:0]     ctx_pc4_reg;
  logic [XLEN-1:0]     ctx_imm_reg;

  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, if_pc[XLEN-1:IDX_BITS+2], if_pc[1:0]};

  assign idx        = if_pc[IDX_BITS+1:2];
  assign pred_taken = taken_vec[idx];

  // Reset is folded in so that no stale context can flush or train while rst_n is low.
  assign train   = rst_n & id_branch & ~stall & ctx_valid_reg;
  assign correct = ~(train & (ctx_pred_reg != id_taken));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bht
      logic [CNT_BITS-1:0] cnt_reg;
      logic [CNT_BITS-1:0] cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (id_taken) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_BITS'(1);
        end else begin
          if (cnt_reg != '0) cnt_next = cnt_reg - CNT_BITS'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= CNT_RESET;
        end else if (train && (ctx_idx_reg == IDX_BITS'(gi))) begin
          cnt_reg <= cnt_next;
        end
      end

      assign taken_vec[gi] = cnt_reg[CNT_BITS-1];
    end
  endgenerate

  // A branch fetched in the same cycle as a mispredict is wrong-path and never captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctx_valid_reg <= 1'b0;
      ctx_pred_reg  <= 1'b0;
      ctx_idx_reg   <= '0;
      ctx_pc4_reg   <= '0;
      ctx_imm_reg   <= '0;
    end else if (!stall) begin
      ctx_valid_reg <= if_branch & correct;
      if (if_branch && correct) begin
        ctx_pred_reg <= pred_taken;
        ctx_idx_reg  <= idx;
        ctx_pc4_reg  <= if_pc_4;
        ctx_imm_reg  <= if_pc_imm;
      end
    end
  end

  always_comb begin
    pc_out = if_pc_4;
    if (rst_n && !stall) begin
      if (!correct) begin
        pc_out = ctx_pred_reg ? ctx_pc4_reg : ctx_imm_reg;
      end else if (if_branch) begin
        pc_out = pred_taken ? if_pc_imm : if_pc_4;
      end else if (id_branch && ctx_valid_reg) begin
        // IF already holds the instruction after the resolved branch; skip past it.
        pc_out = (ctx_pred_reg ? ctx_imm_reg : ctx_pc4_reg) + XLEN'(4);
      end
    end
  end

`ifdef BRPRED_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (train)    stat_branches_reg    <= stat_branches_reg + 32'd1;
      if (!correct) stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: default instance plus a CNT_BITS=3 instance on shared stimulus.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst_n, stall, if_branch, id_branch, id_taken;
  logic [31:0] if_pc, if_pc_4, if_pc_imm;

  logic [31:0] pc_out, stat_branches, stat_mispredicts;
  logic        pred_taken, correct;
  logic [31:0] pc_out3, stat_branches3, stat_mispredicts3;
  logic        pred_taken3, correct3;

  int checks = 0;
  int errors = 0;

  logic        obs_pred_if, obs3_pred_if, obs_correct;
  logic [31:0] obs_pc_if, obs_pc_id;

  branch_predictor_bht u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_branch(if_branch), .if_pc(if_pc), .if_pc_4(if_pc_4), .if_pc_imm(if_pc_imm),
    .id_branch(id_branch), .id_taken(id_taken),
    .pc_out(pc_out), .pred_taken(pred_taken), .correct(correct),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor_bht #(.CNT_BITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .if_branch(if_branch), .if_pc(if_pc), .if_pc_4(if_pc_4), .if_pc_imm(if_pc_imm),
    .id_branch(id_branch), .id_taken(id_taken),
    .pc_out(pc_out3), .pred_taken(pred_taken3), .correct(correct3),
    .stat_branches(stat_branches3), .stat_mispredicts(stat_mispredicts3)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    stall = 0; if_branch = 0; id_branch = 0; id_taken = 0;
    if_pc = 32'h200; if_pc_4 = 32'h204; if_pc_imm = 32'h0;
  endtask

  task automatic do_reset;
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  // IF a branch, resolve it in ID the next cycle; record observed outputs of both cycles.
  task automatic branch_pair(input logic [31:0] pc, input logic [31:0] imm, input logic taken);
    if_branch = 1; if_pc = pc; if_pc_4 = pc + 32'd4; if_pc_imm = imm; id_branch = 0;
    @(negedge clk);
    obs_pred_if = pred_taken; obs3_pred_if = pred_taken3; obs_pc_if = pc_out;
    tick();
    if_branch = 0; if_pc = pc + 32'd4; if_pc_4 = pc + 32'd8; if_pc_imm = 32'h0;
    id_branch = 1; id_taken = taken;
    @(negedge clk);
    obs_correct = correct; obs_pc_id = pc_out;
    $display("branch pc=%h taken=%0b pred=%0b pred3=%0b if_pc_out=%h correct=%0b id_pc_out=%h",
             pc, taken, obs_pred_if, obs3_pred_if, obs_pc_if, obs_correct, obs_pc_id);
    tick();
    idle();
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL reset_correct: got %0b expected 1", correct); end
    checks++; if (pc_out !== 32'h204) begin errors++; $display("FAIL reset_pc_out: got %h expected 00000204", pc_out); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %0b expected 0", pred_taken); end
    checks++; if (pred_taken3 !== 1'b0) begin errors++; $display("FAIL reset_pred3: got %0b expected 0", pred_taken3); end
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    end
    $display("reset done: correct=%0b pc_out=%h pred=%0b", correct, pc_out, pred_taken);
    tick();
  endtask

  task automatic test_not_taken;
    do_reset();
    branch_pair(32'h40, 32'h80, 1'b0);
    checks++; if (obs_pred_if !== 1'b0) begin errors++; $display("FAIL nt_pred: got %0b expected 0", obs_pred_if); end
    checks++; if (obs_pc_if !== 32'h44) begin errors++; $display("FAIL nt_if_pc: got %h expected 00000044", obs_pc_if); end
    checks++; if (obs_correct !== 1'b1) begin errors++; $display("FAIL nt_correct: got %0b expected 1", obs_correct); end
    checks++; if (obs_pc_id !== 32'h48) begin errors++; $display("FAIL nt_id_pc: got %h expected 00000048", obs_pc_id); end
    // Counter now 00: a taken resolve mispredicts and only climbs back to 01.
    branch_pair(32'h40, 32'h80, 1'b1);
    checks++; if (obs_correct !== 1'b0) begin errors++; $display("FAIL nt_mis_correct: got %0b expected 0", obs_correct); end
    checks++; if (obs_pc_id !== 32'h80) begin errors++; $display("FAIL nt_mis_pc: got %h expected 00000080", obs_pc_id); end
    branch_pair(32'h40, 32'h80, 1'b0);
    checks++; if (obs_pred_if !== 1'b0) begin errors++; $display("FAIL nt_pred_after: got %0b expected 0", obs_pred_if); end
  endtask

  task automatic test_taken_train;
    do_reset();
    branch_pair(32'h40, 32'h80, 1'b1);
    checks++; if (obs_pred_if !== 1'b0) begin errors++; $display("FAIL tk_pred1: got %0b expected 0", obs_pred_if); end
    checks++; if (obs_correct !== 1'b0) begin errors++; $display("FAIL tk_correct1: got %0b expected 0", obs_correct); end
    checks++; if (obs_pc_id !== 32'h80) begin errors++; $display("FAIL tk_id_pc1: got %h expected 00000080", obs_pc_id); end
    branch_pair(32'h40, 32'h80, 1'b1);
    checks++; if (obs_pred_if !== 1'b1) begin errors++; $display("FAIL tk_pred2: got %0b expected 1", obs_pred_if); end
    checks++; if (obs_pc_if !== 32'h80) begin errors++; $display("FAIL tk_if_pc2: got %h expected 00000080", obs_pc_if); end
    checks++; if (obs_correct !== 1'b1) begin errors++; $display("FAIL tk_correct2: got %0b expected 1", obs_correct); end
    checks++; if (obs_pc_id !== 32'h84) begin errors++; $display("FAIL tk_id_pc2: got %h expected 00000084", obs_pc_id); end
  endtask

  task automatic test_saturation;
    logic t_tab [10];
    logic e2    [10];
    logic e3    [10];
    t_tab = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    e2    = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    e3    = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      branch_pair(32'h40, 32'h80, t_tab[i]);
      checks++; if (obs_pred_if !== e2[i]) begin
        errors++; $display("FAIL sat_pred2 step %0d: got %0b expected %0b", i, obs_pred_if, e2[i]);
      end
      checks++; if (obs3_pred_if !== e3[i]) begin
        errors++; $display("FAIL sat_pred3 step %0d: got %0b expected %0b", i, obs3_pred_if, e3[i]);
      end
      checks++; if (obs_correct !== (e2[i] == t_tab[i])) begin
        errors++; $display("FAIL sat_correct step %0d: got %0b expected %0b", i, obs_correct, (e2[i] == t_tab[i]));
      end
    end
  endtask

  task automatic test_alias;
    do_reset();
    if_branch = 1; if_pc = 32'h40; if_pc_4 = 32'h44; if_pc_imm = 32'h80;
    tick();
    // ID trains idx 0 (01->10) while IF looks up 0x80, which also maps to idx 0.
    if_pc = 32'h80; if_pc_4 = 32'h84; if_pc_imm = 32'h100; id_branch = 1; id_taken = 1;
    @(negedge clk);
    $display("alias same-cycle: pred=%0b correct=%0b pc_out=%h", pred_taken, correct, pc_out);
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_same_cycle_pred: got %0b expected 0", pred_taken); end
    checks++; if (correct !== 1'b0) begin errors++; $display("FAIL alias_correct: got %0b expected 0", correct); end
    checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL alias_pc: got %h expected 00000080", pc_out); end
    tick();
    id_branch = 0; id_taken = 0;
    @(negedge clk);
    $display("alias after: pred=%0b pc_out=%h", pred_taken, pc_out);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_after_pred: got %0b expected 1", pred_taken); end
    checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL alias_after_pc: got %h expected 00000100", pc_out); end
    tick();
    idle();
  endtask

  task automatic test_stall;
    do_reset();
    if_branch = 1; if_pc = 32'h40; if_pc_4 = 32'h44; if_pc_imm = 32'h80;
    tick();
    stall = 1; id_branch = 1; id_taken = 1;
    if_branch = 1; if_pc = 32'h100; if_pc_4 = 32'h104; if_pc_imm = 32'h300;
    @(negedge clk);
    $display("stall cycle: correct=%0b pc_out=%h", correct, pc_out);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL stall_correct: got %0b expected 1", correct); end
    checks++; if (pc_out !== 32'h104) begin errors++; $display("FAIL stall_pc: got %h expected 00000104", pc_out); end
    tick();
    stall = 0; if_branch = 0; if_pc = 32'h44; if_pc_4 = 32'h48; if_pc_imm = 32'h0;
    @(negedge clk);
    $display("unstall cycle: correct=%0b pc_out=%h", correct, pc_out);
    checks++; if (correct !== 1'b0) begin errors++; $display("FAIL unstall_correct: got %0b expected 0", correct); end
    checks++; if (pc_out !== 32'h80) begin errors++; $display("FAIL unstall_pc: got %h expected 00000080", pc_out); end
    tick();
    idle();
    // Exactly one training happened (01->10); one not-taken brings it back below the threshold.
    branch_pair(32'h40, 32'h80, 1'b0);
    checks++; if (obs_pred_if !== 1'b1) begin errors++; $display("FAIL stall_pred_a: got %0b expected 1", obs_pred_if); end
    checks++; if (obs_pc_id !== 32'h44) begin errors++; $display("FAIL stall_mis_pc: got %h expected 00000044", obs_pc_id); end
    branch_pair(32'h40, 32'h80, 1'b0);
    checks++; if (obs_pred_if !== 1'b0) begin errors++; $display("FAIL stall_pred_b: got %0b expected 0", obs_pred_if); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    if_branch = 1; if_pc = 32'h40; if_pc_4 = 32'h44; if_pc_imm = 32'h80;
    tick();
    if_pc = 32'h44; if_pc_4 = 32'h48; if_pc_imm = 32'h10; id_branch = 1; id_taken = 0;
    @(negedge clk);
    $display("b2b c2: pred=%0b correct=%0b pc_out=%h", pred_taken, correct, pc_out);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL b2b_c2_correct: got %0b expected 1", correct); end
    checks++; if (pc_out !== 32'h48) begin errors++; $display("FAIL b2b_c2_pc: got %h expected 00000048", pc_out); end
    tick();
    if_pc = 32'h48; if_pc_4 = 32'h4c; if_pc_imm = 32'h20; id_taken = 1;
    @(negedge clk);
    $display("b2b c3: correct=%0b pc_out=%h", correct, pc_out);
    checks++; if (correct !== 1'b0) begin errors++; $display("FAIL b2b_c3_correct: got %0b expected 0", correct); end
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL b2b_c3_pc: got %h expected 00000010", pc_out); end
    tick();
    // The wrong-path branch at 0x48 was not captured, so this resolve has no context.
    if_branch = 0; if_pc = 32'h10; if_pc_4 = 32'h14; if_pc_imm = 32'h0;
    @(negedge clk);
    $display("b2b c4: correct=%0b pc_out=%h", correct, pc_out);
    checks++; if (correct !== 1'b1) begin errors++; $display("FAIL b2b_c4_correct: got %0b expected 1", correct); end
    checks++; if (pc_out !== 32'h14) begin errors++; $display("FAIL b2b_c4_pc: got %h expected 00000014", pc_out); end
    tick();
    idle();
  endtask

  task automatic test_stats;
    logic        tk;
    logic [31:0] exp_br, exp_mis;
`ifdef BRPRED_STATS_EN
    exp_br = 32'd10; exp_mis = 32'd3;
`else
    exp_br = 32'd0;  exp_mis = 32'd0;
`endif
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tk = (i == 2) || (i == 5) || (i == 8);
      branch_pair(32'(i * 4), 32'h400, tk);
      checks++; if (obs_correct !== !tk) begin
        errors++; $display("FAIL stats_correct %0d: got %0b expected %0b", i, obs_correct, !tk);
      end
    end
    @(negedge clk);
    $display("stats: branches=%0d mispredicts=%0d", stat_branches, stat_mispredicts);
    checks++; if (stat_branches !== exp_br) begin errors++; $display("FAIL stats_branches: got %0d expected %0d", stat_branches, exp_br); end
    checks++; if (stat_mispredicts !== exp_mis) begin errors++; $display("FAIL stats_mispredicts: got %0d expected %0d", stat_mispredicts, exp_mis); end
    tick();
    do_reset();
    @(negedge clk);
    checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      errors++; $display("FAIL stats_reset: got %0d/%0d expected 0/0", stat_branches, stat_mispredicts);
    end
    tick();
  endtask

  initial begin
    idle();
    rst_n = 0;
    test_reset();
    test_not_taken();
    test_taken_train();
    test_saturation();
    test_alias();
    test_stall();
    test_back_to_back();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
